// File: rtl/cpu_control_fsm.sv
// Moore sequencer for the Simple RISC Machine: fetch, decode and multi-cycle execute of each instruction.
// Latency: 5 to 10 clocks per instruction, from IF1 to the last execute state; every output is decoded from state only.
// Backpressure: none. Memory is assumed single-cycle, and HALT holds until reset.
module cpu_control_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   output logic [2:0] nsel,
   output logic [1:0] vsel,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       asel,
   output logic       bsel,
   output logic       write,
   output logic       load_ir,
   output logic       load_pc,
   output logic       reset_pc,
   output logic       addr_sel,
   output logic       load_addr,
   output logic [1:0] mem_cmd,
   output logic       halted
);
   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   localparam logic [2:0] NS_RN = 3'b100;
   localparam logic [2:0] NS_RD = 3'b010;
   localparam logic [2:0] NS_RM = 3'b001;

   // Each instruction class has its own copy of the shared operand states,
   // so the successor is a function of state alone.
   typedef enum logic [4:0] {
      S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM,
      S_MOV_GETB, S_MOV_EXE, S_MOV_WRD,
      S_ALU_GETA, S_ALU_GETB, S_ALU_EXE, S_ALU_WRD,
      S_CMP_GETA, S_CMP_GETB, S_CMPX,
      S_MVN_GETB, S_MVN_EXE, S_MVN_WRD,
      S_LDR_GETA, S_LDR_ADR, S_LDR_LADR, S_MRD, S_WBL,
      S_STR_GETA, S_STR_ADR, S_STR_LADR, S_GETBD, S_MOVB, S_MWR,
      S_HALT
   } state_t;

   state_t state, state_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_RST;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_RST:      state_nxt = S_IF1;
         S_IF1:      state_nxt = S_IF2;
         S_IF2:      state_nxt = S_UPC;
         S_UPC:      state_nxt = S_DEC;
         S_DEC: begin
            casez ({opcode, op})
               5'b110_10:          state_nxt = S_WIMM;
               5'b110_00:          state_nxt = S_MOV_GETB;
               5'b101_00, 5'b101_10: state_nxt = S_ALU_GETA;
               5'b101_01:          state_nxt = S_CMP_GETA;
               5'b101_11:          state_nxt = S_MVN_GETB;
               5'b011_00:          state_nxt = S_LDR_GETA;
               5'b100_00:          state_nxt = S_STR_GETA;
               5'b111_??:          state_nxt = S_HALT;
               default:            state_nxt = S_IF1;
            endcase
         end
         S_WIMM:     state_nxt = S_IF1;
         S_MOV_GETB: state_nxt = S_MOV_EXE;
         S_MOV_EXE:  state_nxt = S_MOV_WRD;
         S_MOV_WRD:  state_nxt = S_IF1;
         S_ALU_GETA: state_nxt = S_ALU_GETB;
         S_ALU_GETB: state_nxt = S_ALU_EXE;
         S_ALU_EXE:  state_nxt = S_ALU_WRD;
         S_ALU_WRD:  state_nxt = S_IF1;
         S_CMP_GETA: state_nxt = S_CMP_GETB;
         S_CMP_GETB: state_nxt = S_CMPX;
         S_CMPX:     state_nxt = S_IF1;
         S_MVN_GETB: state_nxt = S_MVN_EXE;
         S_MVN_EXE:  state_nxt = S_MVN_WRD;
         S_MVN_WRD:  state_nxt = S_IF1;
         S_LDR_GETA: state_nxt = S_LDR_ADR;
         S_LDR_ADR:  state_nxt = S_LDR_LADR;
         S_LDR_LADR: state_nxt = S_MRD;
         S_MRD:      state_nxt = S_WBL;
         S_WBL:      state_nxt = S_IF1;
         S_STR_GETA: state_nxt = S_STR_ADR;
         S_STR_ADR:  state_nxt = S_STR_LADR;
         S_STR_LADR: state_nxt = S_GETBD;
         S_GETBD:    state_nxt = S_MOVB;
         S_MOVB:     state_nxt = S_MWR;
         S_MWR:      state_nxt = S_IF1;
         S_HALT:     state_nxt = S_HALT;
         default:    state_nxt = S_RST;
      endcase
   end

   always_comb begin
      nsel      = 3'b000;
      vsel      = 2'b00;
      loada     = 1'b0;
      loadb     = 1'b0;
      loadc     = 1'b0;
      loads     = 1'b0;
      asel      = 1'b0;
      bsel      = 1'b0;
      write     = 1'b0;
      load_ir   = 1'b0;
      load_pc   = 1'b0;
      reset_pc  = 1'b0;
      addr_sel  = 1'b0;
      load_addr = 1'b0;
      mem_cmd   = MNONE;
      halted    = 1'b0;
      case (state)
         S_RST:      begin reset_pc = 1'b1; load_pc = 1'b1; end
         S_IF1:      begin addr_sel = 1'b1; mem_cmd = MREAD; end
         S_IF2:      begin addr_sel = 1'b1; mem_cmd = MREAD; load_ir = 1'b1; end
         S_UPC:      load_pc = 1'b1;
         S_WIMM:     begin nsel = NS_RN; vsel = 2'b10; write = 1'b1; end
         S_MOV_GETB, S_ALU_GETB, S_CMP_GETB, S_MVN_GETB:
                     begin nsel = NS_RM; loadb = 1'b1; end
         S_ALU_GETA, S_CMP_GETA, S_LDR_GETA, S_STR_GETA:
                     begin nsel = NS_RN; loada = 1'b1; end
         S_MOV_EXE, S_MOVB:
                     begin asel = 1'b1; loadc = 1'b1; end
         S_ALU_EXE, S_MVN_EXE:
                     loadc = 1'b1;
         S_MOV_WRD, S_ALU_WRD, S_MVN_WRD:
                     begin nsel = NS_RD; vsel = 2'b00; write = 1'b1; end
         S_CMPX:     loads = 1'b1;
         S_LDR_ADR, S_STR_ADR:
                     begin bsel = 1'b1; loadc = 1'b1; end
         S_LDR_LADR, S_STR_LADR:
                     load_addr = 1'b1;
         S_MRD:      mem_cmd = MREAD;
         S_WBL:      begin mem_cmd = MREAD; nsel = NS_RD; vsel = 2'b11; write = 1'b1; end
         S_GETBD:    begin nsel = NS_RD; loadb = 1'b1; end
         S_MWR:      mem_cmd = MWRITE;
         S_HALT:     halted = 1'b1;
         default:    ;
      endcase
   end
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: wraps the FSM in a behavioural datapath and memory, runs small programs,
// and scoreboards register/memory writes against expected values.
module tb_cpu_control_fsm;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;
   // Output vector layout: {nsel,vsel,loada,loadb,loadc,loads,asel,bsel,write,load_ir,load_pc,reset_pc,addr_sel,load_addr,mem_cmd,halted}
   localparam logic [19:0] RST_OUT  = 20'h00060;
   localparam logic [19:0] IF1_OUT  = 20'h00012;
   localparam logic [19:0] IF2_OUT  = 20'h00092;
   localparam logic [19:0] UPC_OUT  = 20'h00040;
   localparam logic [19:0] DEC_OUT  = 20'h00000;
   localparam logic [19:0] HALT_OUT = 20'h00001;

   logic       clk, reset;
   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] nsel;
   logic [1:0] vsel, mem_cmd;
   logic       loada, loadb, loadc, loads, asel, bsel, write, load_ir;
   logic       load_pc, reset_pc, addr_sel, load_addr, halted;
   logic [19:0] outs;

   cpu_control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .op(op), .nsel(nsel), .vsel(vsel),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
      .write(write), .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
      .addr_sel(addr_sel), .load_addr(load_addr), .mem_cmd(mem_cmd), .halted(halted)
   );

   assign outs = {nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, load_ir,
                  load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural datapath: regfile, A/B/C, status, shifter, ALU, PC, data-address reg, memory
   logic [15:0] mem [0:255];
   logic [15:0] rf  [0:7];
   logic [15:0] ir, ra, rb, rc, sh_out, ain, bin, alu_out, wdata, mdata, sximm5, sximm8;
   logic [8:0]  pc, dar, mem_addr;
   logic [2:0]  regnum;
   logic        z_f, n_f, v_f, v_out;
   logic        prog_we;
   logic [7:0]  prog_addr;
   logic [15:0] prog_dat;

   assign opcode   = ir[15:13];
   assign op       = ir[12:11];
   assign sximm5   = {{11{ir[4]}}, ir[4:0]};
   assign sximm8   = {{8{ir[7]}}, ir[7:0]};
   assign mem_addr = addr_sel ? pc : dar;
   assign mdata    = mem[mem_addr[7:0]];
   assign ain      = asel ? 16'h0000 : ra;
   assign bin      = bsel ? sximm5 : sh_out;

   always_comb begin
      regnum = 3'd0;
      case (nsel)
         3'b100:  regnum = ir[10:8];
         3'b010:  regnum = ir[7:5];
         3'b001:  regnum = ir[2:0];
         default: regnum = 3'd0;
      endcase
      sh_out = rb;
      case (ir[4:3])
         2'b01:   sh_out = {rb[14:0], 1'b0};
         2'b10:   sh_out = {1'b0, rb[15:1]};
         2'b11:   sh_out = {rb[15], rb[15:1]};
         default: sh_out = rb;
      endcase
      alu_out = 16'h0000;
      v_out   = 1'b0;
      case (op)
         2'b00: alu_out = ain + bin;
         2'b01: begin
            alu_out = ain - bin;
            v_out   = (ain[15] ^ bin[15]) & (alu_out[15] ^ ain[15]);
         end
         2'b10: alu_out = ain & bin;
         default: alu_out = ~bin;
      endcase
      wdata = rc;
      case (vsel)
         2'b01:   wdata = {7'd0, pc};
         2'b10:   wdata = sximm8;
         2'b11:   wdata = mdata;
         default: wdata = rc;
      endcase
   end

   always @(posedge clk) begin
      if (prog_we) mem[prog_addr] <= prog_dat;
      else if (mem_cmd == MWRITE) mem[mem_addr[7:0]] <= rc;
      if (write)     rf[regnum] <= wdata;
      if (load_ir)   ir <= mdata;
      if (loada)     ra <= rf[regnum];
      if (loadb)     rb <= rf[regnum];
      if (loadc)     rc <= alu_out;
      if (loads)     {z_f, n_f, v_f} <= {alu_out == 16'h0000, alu_out[15], v_out};
      if (load_addr) dar <= rc[8:0];
      if (load_pc)   pc <= reset_pc ? 9'd0 : pc + 9'd1;
   end

   // Instruction encoders
   function automatic logic [15:0] mov_i(input logic [2:0] rn, input logic [7:0] im);
      return {5'b110_10, rn, im};
   endfunction
   function automatic logic [15:0] mov_r(input logic [2:0] rd, input logic [2:0] rm, input logic [1:0] sh);
      return {5'b110_00, 3'd0, rd, sh, rm};
   endfunction
   function automatic logic [15:0] alu_i(input logic [1:0] aop, input logic [2:0] rn, input logic [2:0] rd, input logic [2:0] rm);
      return {3'b101, aop, rn, rd, 2'b00, rm};
   endfunction
   function automatic logic [15:0] mem_i(input logic [2:0] opc, input logic [2:0] rd, input logic [2:0] rn, input logic [4:0] im);
      return {opc, 2'b00, rn, rd, im};
   endfunction

   typedef struct { int cyc; logic [2:0] rg; logic [15:0] val; } wr_t;
   typedef struct { int cyc; logic [8:0] a; logic [15:0] d; } mw_t;
   wr_t wq[$];
   mw_t mq[$];

   int total = 0;
   int bad   = 0;
   int cyc, mrd_cnt, mwr_cnt, loads_cnt, cmp_viol, hold_ok;
   logic [8:0] pc0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_wr(input int c, input logic [2:0] r, input logic [15:0] v);
      wr_t w;
      w.cyc = c; w.rg = r; w.val = v;
      wq.push_back(w);
   endtask

   task automatic step();
      wr_t w;
      mw_t m;
      @(posedge clk); #1;
      if (!reset) cyc++;
      if (write) begin
         chk("wr_expected", 32'(wq.size() != 0), 32'd1);
         chk("wr_not_mwrite", 32'(mem_cmd != MWRITE), 32'd1);
         if (wq.size() != 0) begin
            w = wq.pop_front();
            if (w.cyc >= 0) chk("wr_cycle", 32'(cyc), 32'(w.cyc));
            chk("wr_reg", 32'(regnum), 32'(w.rg));
            chk("wr_val", 32'(wdata), 32'(w.val));
         end
      end
      if (mem_cmd == MWRITE) begin
         mwr_cnt++;
         chk("mwr_expected", 32'(mq.size() != 0), 32'd1);
         if (mq.size() != 0) begin
            m = mq.pop_front();
            chk("mwr_cycle", 32'(cyc), 32'(m.cyc));
            chk("mwr_addr", 32'(mem_addr), 32'(m.a));
            chk("mwr_data", 32'(rc), 32'(m.d));
         end
      end
      if (mem_cmd == MREAD && !addr_sel) mrd_cnt++;
      if (loads) loads_cnt++;
      if (ir[15:11] == 5'b101_01 && (loadc || write)) cmp_viol++;
   endtask

   task automatic hold_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [7:0] a, input logic [15:0] d);
      prog_addr = a; prog_dat = d; prog_we = 1'b1;
      @(posedge clk); #1;
      prog_we = 1'b0;
   endtask

   task automatic release_rst();
      @(negedge clk);
      reset = 1'b0;
      cyc = 0; mrd_cnt = 0; mwr_cnt = 0; loads_cnt = 0; cmp_viol = 0;
   endtask

   task automatic run_to_halt(input string tag, input int max, input int exp_cyc);
      for (int i = 0; i < max && !halted; i++) step();
      chk({tag, "_halt_reached"}, 32'(halted), 32'd1);
      chk({tag, "_halt_cycle"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_wq_drained"}, 32'(wq.size()), 32'd0);
   endtask

   initial begin
      reset = 1'b1; prog_we = 1'b0; prog_addr = 8'd0; prog_dat = 16'd0;
      #1;
      chk("reset_outputs", 32'(outs), 32'(RST_OUT));

      // Reset aborting ADD during its EXE state
      hold_reset();
      poke(8'd0, mov_i(3'd0, 8'd7));
      poke(8'd1, mov_i(3'd1, 8'd2));
      poke(8'd2, alu_i(2'b00, 3'd0, 3'd2, 3'd1));
      poke(8'd3, 16'hE000);
      push_wr(5, 3'd0, 16'd7);
      push_wr(10, 3'd1, 16'd2);
      release_rst();
      chk("rst_held_until_edge", 32'(outs), 32'(RST_OUT));
      step(); chk("if1_outputs", 32'(outs), 32'(IF1_OUT));
      step(); chk("if2_outputs", 32'(outs), 32'(IF2_OUT));
      step(); chk("upc_outputs", 32'(outs), 32'(UPC_OUT));
      step(); chk("dec_outputs", 32'(outs), 32'(DEC_OUT));
      for (int i = 0; i < 40 && !(loadc && !asel && !bsel); i++) step();
      chk("add_exe_found", 32'(loadc & ~asel), 32'd1);
      chk("add_exe_cycle", 32'(cyc), 32'd17);
      #2 reset = 1'b1;
      #1 chk("abort_outputs", 32'(outs), 32'(RST_OUT));
      @(posedge clk); #1;
      release_rst();
      step();
      chk("if1_after_abort", 32'(outs), 32'(IF1_OUT));
      chk("if1_after_abort_cyc", 32'(cyc), 32'd1);
      chk("abort_wq_drained", 32'(wq.size()), 32'd0);

      // MOV/MOV/ADD, write pulses at 5, 10, 18; then HALT hold and restart
      hold_reset();
      push_wr(5, 3'd0, 16'd7);
      push_wr(10, 3'd1, 16'd2);
      push_wr(18, 3'd2, 16'd9);
      release_rst();
      run_to_halt("add", 60, 23);
      chk("add_r2", 32'(rf[2]), 32'd9);
      chk("halt_pc", 32'(pc), 32'd4);
      pc0 = pc;
      hold_ok = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (outs == HALT_OUT && pc == pc0) hold_ok++;
      end
      chk("halt_hold_50", 32'(hold_ok), 32'd50);
      reset = 1'b1;
      #1 chk("halt_cleared", 32'(halted), 32'd0);
      @(posedge clk); #1;
      release_rst();
      step();
      chk("restart_if1", 32'(outs), 32'(IF1_OUT));
      chk("restart_pc", 32'(pc), 32'd0);
      chk("restart_addr", 32'(mem_addr), 32'd0);

      // CMP R3,R3
      hold_reset();
      poke(8'd0, mov_i(3'd3, 8'd5));
      poke(8'd1, alu_i(2'b01, 3'd3, 3'd0, 3'd3));
      poke(8'd2, 16'hE000);
      push_wr(5, 3'd3, 16'd5);
      release_rst();
      run_to_halt("cmp", 40, 17);
      chk("cmp_flags_znv", 32'({z_f, n_f, v_f}), 32'b100);
      chk("cmp_no_loadc_write", 32'(cmp_viol), 32'd0);
      chk("cmp_loads_once", 32'(loads_cnt), 32'd1);

      // LDR R1,[R0,#4] with R0=0x1C
      hold_reset();
      poke(8'h20, 16'hABCD);
      poke(8'd0, mov_i(3'd0, 8'h1C));
      poke(8'd1, mem_i(3'b011, 3'd1, 3'd0, 5'd4));
      poke(8'd2, 16'hE000);
      push_wr(5, 3'd0, 16'h001C);
      push_wr(14, 3'd1, 16'hABCD);
      release_rst();
      run_to_halt("ldr", 40, 19);
      chk("ldr_r1", 32'(rf[1]), 32'hABCD);
      chk("ldr_mread_data_cycles", 32'(mrd_cnt), 32'd2);

      // STR R4,[R0,#0] with R4=0x1234 (loaded from memory), R0=0x30
      hold_reset();
      poke(8'h40, 16'h1234);
      poke(8'h30, 16'h0000);
      poke(8'd0, mov_i(3'd5, 8'h40));
      poke(8'd1, mem_i(3'b011, 3'd4, 3'd5, 5'd0));
      poke(8'd2, mov_i(3'd0, 8'h30));
      poke(8'd3, mem_i(3'b100, 3'd4, 3'd0, 5'd0));
      poke(8'd4, 16'hE000);
      push_wr(5, 3'd5, 16'h0040);
      push_wr(14, 3'd4, 16'h1234);
      push_wr(19, 3'd0, 16'h0030);
      begin
         mw_t m;
         m.cyc = 29; m.a = 9'h030; m.d = 16'h1234;
         mq.push_back(m);
      end
      release_rst();
      run_to_halt("str", 60, 34);
      chk("str_mem30", 32'(mem[8'h30]), 32'h1234);
      chk("str_one_mwrite", 32'(mwr_cnt), 32'd1);
      chk("str_mq_drained", 32'(mq.size()), 32'd0);

      // MVN, MOV with LSL, AND
      hold_reset();
      poke(8'd0, mov_i(3'd0, 8'h0F));
      poke(8'd1, alu_i(2'b11, 3'd0, 3'd1, 3'd0));
      poke(8'd2, mov_r(3'd3, 3'd0, 2'b01));
      poke(8'd3, alu_i(2'b10, 3'd1, 3'd2, 3'd3));
      poke(8'd4, 16'hE000);
      push_wr(5, 3'd0, 16'h000F);
      push_wr(12, 3'd1, 16'hFFF0);
      push_wr(19, 3'd3, 16'h001E);
      push_wr(27, 3'd2, 16'h0010);
      release_rst();
      run_to_halt("alu", 60, 32);
      chk("alu_halt_outputs", 32'(outs), 32'(HALT_OUT));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
